// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses SYNC/CMD/D0/D1/CSUM frames from a byte stream,
// updates the display or LED register, and queues a one-byte ACK/NAK response.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC        = 8'hA5,
  parameter int         TIMEOUT_CYC = 50_000,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_vld,
  output logic [15:0] o_disp_data,
  output logic        o_disp_we,
  output logic [7:0]  o_led,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic        o_err,
  output logic        o_rsp_drop
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_D0   = 3'd2;
  localparam logic [2:0] S_D1   = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;

  localparam logic [7:0] CMD_DISP = 8'h01;
  localparam logic [7:0] CMD_LED  = 8'h02;

  function automatic logic [7:0] calc_csum(input logic [7:0] c, input logic [7:0] a,
                                           input logic [7:0] b);
    calc_csum = c ^ a ^ b;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_q, cmd_d, d0_q, d0_d, d1_q, d1_d;
  logic [15:0]   disp_q, disp_d;
  logic          disp_we_q, disp_we_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_vld_q, tx_vld_d;
  logic          err_q, err_d;
  logic          drop_q, drop_d;
  logic          rsp_new_s;
  logic [7:0]    rsp_byte_s;

  // Frame parser, timeout supervisor and response holding register
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    cmd_d      = cmd_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    disp_d     = disp_q;
    disp_we_d  = 1'b0;
    led_d      = led_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    err_d      = 1'b0;
    drop_d     = drop_q;
    rsp_new_s  = 1'b0;
    rsp_byte_s = NAK_BYTE;

    if (state_q == S_IDLE || i_vld) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      // Truncated frame: drop it silently on the response side
      tmo_d   = '0;
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else begin
      tmo_d = tmo_q + CW'(1);
    end

    if (i_vld) begin
      case (state_q)
        S_IDLE: begin
          if (i_data == SYNC) begin
            state_d = S_CMD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          cmd_d   = i_data;
          state_d = S_D0;
        end
        S_D0: begin
          d0_d    = i_data;
          state_d = S_D1;
        end
        S_D1: begin
          d1_d    = i_data;
          state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d   = S_IDLE;
          rsp_new_s = 1'b1;
          if (i_data != calc_csum(cmd_q, d0_q, d1_q)) begin
            err_d = 1'b1;
          end else begin
            case (cmd_q)
              CMD_DISP: begin
                disp_d     = {d1_q, d0_q};
                disp_we_d  = 1'b1;
                rsp_byte_s = ACK_BYTE;
              end
              CMD_LED: begin
                led_d      = d0_q;
                rsp_byte_s = ACK_BYTE;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_d;
    end

    // A pending response accepted this cycle frees the slot for a new one
    if (rsp_new_s) begin
      if (!tx_vld_q || i_tx_rdy) begin
        tx_data_d = rsp_byte_s;
        tx_vld_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (tx_vld_q && i_tx_rdy) begin
      tx_vld_d = 1'b0;
    end else begin
      tx_vld_d = tx_vld_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      cmd_q     <= 8'h00;
      d0_q      <= 8'h00;
      d1_q      <= 8'h00;
      disp_q    <= 16'h0000;
      disp_we_q <= 1'b0;
      led_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      disp_q    <= disp_d;
      disp_we_q <= disp_we_d;
      led_q     <= led_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign o_disp_data = disp_q;
  assign o_disp_we   = disp_we_q;
  assign o_led       = led_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_vld    = tx_vld_q;
  assign o_err       = err_q;
  assign o_rsp_drop  = drop_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: vector table for frame parsing and the
// response channel, plus hand-written timeout and asynchronous-reset sequences.
module tb_uart_cmd_ctrl;

  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_vld = 1'b0;
  logic        i_tx_rdy = 1'b0;
  logic [15:0] o_disp_data;
  logic        o_disp_we;
  logic [7:0]  o_led;
  logic [7:0]  o_tx_data;
  logic        o_tx_vld;
  logic        o_err;
  logic        o_rsp_drop;

  int errors = 0;
  int checks = 0;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TC)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld),
    .o_disp_data(o_disp_data), .o_disp_we(o_disp_we), .o_led(o_led),
    .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy),
    .o_err(o_err), .o_rsp_drop(o_rsp_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic [35:0] exp;  // {disp, we, led, tx_data, tx_vld, err, drop}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [35:0] pack_out(input logic [15:0] disp, input logic we,
      input logic [7:0] led, input logic [7:0] txd, input logic txv, input logic err,
      input logic drop);
    pack_out = {disp, we, led, txd, txv, err, drop};
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic rdy,
      input logic [15:0] disp, input logic we, input logic [7:0] led,
      input logic [7:0] txd, input logic txv, input logic err, input logic drop);
    vec_t r;
    r.vld = v; r.data = d; r.rdy = rdy;
    r.exp = pack_out(disp, we, led, txd, txv, err, drop);
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: drive at negedge, observe 1 time unit after the capturing edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    i_vld = v; i_data = d; i_tx_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] obs();
    obs = pack_out(o_disp_data, o_disp_we, o_led, o_tx_data, o_tx_vld, o_err, o_rsp_drop);
  endfunction

  initial begin
    int found;
    logic seen;

    // Display write, then hold ACK until accepted
    add(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h34, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h12, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h27, 1'b0, 16'h1234, 1'b1, 8'h00, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
    // LED write, then checksum error
    add(1'b1, 8'hA5, 1'b0, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h5A, 1'b0, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h58, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hA5, 1'b1, 16'h1234, 1'b0, 8'h5A, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h06, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    // Noise then unknown command 07
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h07, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h07, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    // Accept-and-load collision: ACK pending, NAK loaded in the accepting cycle
    add(1'b1, 8'hA5, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h22, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h5A, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h20, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h33, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h22, 8'h15, 1'b1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h22, 8'h15, 1'b0, 1'b0, 1'b0);
    // Overflow: two back-to-back ACKs with rdy low
    add(1'b1, 8'hA5, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hAB, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'hCD, 1'b0, 16'h1234, 1'b0, 8'h22, 8'h15, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h67, 1'b0, 16'hCDAB, 1'b1, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 16'hCDAB, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b0, 16'hCDAB, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h11, 1'b0, 16'hCDAB, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 16'hCDAB, 1'b0, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h13, 1'b0, 16'hCDAB, 1'b0, 8'h11, 8'h06, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'hCDAB, 1'b0, 8'h11, 8'h06, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 16'hCDAB, 1'b0, 8'h11, 8'h06, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 16'hCDAB, 1'b0, 8'h11, 8'h06, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'(obs()), 64'(36'h0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].vld, vecs[i].data, vecs[i].rdy);
      chk($sformatf("vec%0d", i), 64'(obs()), 64'(vecs[i].exp));
    end

    // Timeout after A5 01 34: err exactly TC idle cycles later, no response
    cyc(1'b1, 8'hA5, 1'b0); cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'h34, 1'b0);
    found = 0;
    for (int k = 1; k <= TC + 5; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (o_err && found == 0) found = k;
    end
    chk("timeout_cycle", 64'(found), 64'(TC));
    chk("timeout_no_rsp", 64'(o_tx_vld), 64'(1'b0));
    cyc(1'b1, 8'hA5, 1'b0); cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'hBE, 1'b0);
    cyc(1'b1, 8'hEF, 1'b0); cyc(1'b1, 8'h50, 1'b0);
    chk("after_timeout_disp", 64'(o_disp_data), 64'(16'hEFBE));
    chk("after_timeout_ack", 64'({o_tx_vld, o_tx_data}), 64'({1'b1, 8'h06}));
    cyc(1'b0, 8'h00, 1'b1);

    // Byte arriving exactly at terminal count is processed
    seen = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0);
    repeat (TC - 1) begin
      cyc(1'b0, 8'h00, 1'b0);
      seen = seen | o_err;
    end
    cyc(1'b1, 8'h01, 1'b0); seen = seen | o_err;
    cyc(1'b1, 8'h34, 1'b0); seen = seen | o_err;
    cyc(1'b1, 8'h12, 1'b0); seen = seen | o_err;
    cyc(1'b1, 8'h27, 1'b0); seen = seen | o_err;
    chk("terminal_race_no_err", 64'(seen), 64'(1'b0));
    chk("terminal_race_disp", 64'({o_disp_data, o_tx_vld}), 64'({16'h1234, 1'b1}));

    // Asynchronous reset mid-frame clears everything, partial frame lost
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hA5, 1'b0); cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'h12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'(obs()), 64'(36'h0));
    @(negedge clk);
    i_vld = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    cyc(1'b1, 8'h34, 1'b0); seen = seen | o_disp_we | o_tx_vld;
    cyc(1'b1, 8'h27, 1'b0); seen = seen | o_disp_we | o_tx_vld;
    cyc(1'b0, 8'h00, 1'b0); seen = seen | o_disp_we | o_tx_vld;
    cyc(1'b0, 8'h00, 1'b0); seen = seen | o_disp_we | o_tx_vld;
    chk("post_reset_no_action", 64'(seen), 64'(1'b0));
    chk("post_reset_state", 64'(obs()), 64'(36'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
